demux_memoria_2bits: RTL and testbench

- 1-to-2 demultiplexer with memory; the splitting counterpart of the 2:1 memory mux.
- Takes one valid-qualified DATA_W-bit stream and steers each word, by selector, into one of two per-lane FIFOs.
- Each lane is drained independently by a pop request and presented on a registered output with its own valid.
- Sits downstream of the mux stage, so paired mux/demux benches can round-trip data.

---
 rtl/demux_memoria_2bits_if.sv | 36 +++
 rtl/demux_memoria_2bits.sv | 118 +++++++++++
 tb/tb_demux_memoria_2bits.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/demux_memoria_2bits_if.sv
// Stream-in / two-lane-out bundle for the 1:2 memory demux.
interface demux_memoria_2bits_if #(
    parameter int unsigned DATA_W = 2
);
    logic [DATA_W-1:0] data_in;
    logic              valid_in;
    logic              selector;
    logic              pop_0;
    logic              pop_1;
    logic [DATA_W-1:0] data_out0;
    logic              valid_out0;
    logic [DATA_W-1:0] data_out1;
    logic              valid_out1;
    logic              full_0;
    logic              full_1;
    logic              empty_0;
    logic              empty_1;
    logic              overflow_0;
    logic              overflow_1;
    logic              underflow_0;
    logic              underflow_1;

    modport master (
        output data_in, valid_in, selector, pop_0, pop_1,
        input  data_out0, valid_out0, data_out1, valid_out1,
        input  full_0, full_1, empty_0, empty_1,
        input  overflow_0, overflow_1, underflow_0, underflow_1
    );

    modport slave (
        input  data_in, valid_in, selector, pop_0, pop_1,
        output data_out0, valid_out0, data_out1, valid_out1,
        output full_0, full_1, empty_0, empty_1,
        output overflow_0, overflow_1, underflow_0, underflow_1
    );
endinterface

// File: rtl/demux_memoria_2bits.sv
// 1:2 demux with memory: steers a valid-qualified stream into two
// independently drained lane FIFOs with registered outputs and sticky error flags.
module demux_memoria_2bits #(
    parameter int unsigned DATA_W = 2,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned PTR_W  = 2
) (
    input logic                  clk,
    input logic                  reset,
    demux_memoria_2bits_if.slave bus
);
    localparam int unsigned LANES = 2;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q    [LANES][DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q [LANES];
    logic [PTR_W-1:0]  wr_ptr_d [LANES];
    logic [PTR_W-1:0]  rd_ptr_q [LANES];
    logic [PTR_W-1:0]  rd_ptr_d [LANES];
    logic [CNT_W-1:0]  cnt_q    [LANES];
    logic [CNT_W-1:0]  cnt_d    [LANES];
    logic [DATA_W-1:0] dout_q   [LANES];
    logic [DATA_W-1:0] dout_d   [LANES];

    logic [LANES-1:0] pop_req;
    logic [LANES-1:0] sel_hit;
    logic [LANES-1:0] push_ok;
    logic [LANES-1:0] pop_ok;
    logic [LANES-1:0] valid_q, valid_d;
    logic [LANES-1:0] full_q, full_d;
    logic [LANES-1:0] empty_q, empty_d;
    logic [LANES-1:0] ovf_q, ovf_d;
    logic [LANES-1:0] udf_q, udf_d;

    // Accept decisions use the registered flags only, so a pop never frees room for a same-cycle push.
    always_comb begin
        pop_req  = {bus.pop_1, bus.pop_0};
        sel_hit  = '0;
        push_ok  = '0;
        pop_ok   = '0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        valid_d  = '0;
        full_d   = full_q;
        empty_d  = empty_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        for (int l = 0; l < int'(LANES); l++) begin
            sel_hit[l] = bus.valid_in && (bus.selector == 1'(l));
            push_ok[l] = sel_hit[l] && !full_q[l];
            pop_ok[l]  = pop_req[l] && !empty_q[l];
            if (push_ok[l]) begin
                wr_ptr_d[l] = wr_ptr_q[l] + PTR_W'(1);
            end
            if (pop_ok[l]) begin
                rd_ptr_d[l] = rd_ptr_q[l] + PTR_W'(1);
                dout_d[l]   = mem_q[l][rd_ptr_q[l]];
            end
            valid_d[l] = pop_ok[l];
            cnt_d[l]   = cnt_q[l] + CNT_W'(push_ok[l]) - CNT_W'(pop_ok[l]);
            full_d[l]  = (cnt_d[l] == CNT_W'(DEPTH));
            empty_d[l] = (cnt_d[l] == CNT_W'(0));
            ovf_d[l]   = ovf_q[l] | (sel_hit[l] & full_q[l]);
            udf_d[l]   = udf_q[l] | (pop_req[l] & empty_q[l]);
        end
    end

    // Control and output registers; reset overrides any concurrent push or pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int l = 0; l < int'(LANES); l++) begin
                wr_ptr_q[l] <= '0;
                rd_ptr_q[l] <= '0;
                cnt_q[l]    <= '0;
                dout_q[l]   <= '0;
            end
            valid_q <= '0;
            full_q  <= '0;
            empty_q <= '1;
            ovf_q   <= '0;
            udf_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage is never cleared; stale entries are unreachable once the pointers reset.
    always_ff @(posedge clk) begin
        for (int l = 0; l < int'(LANES); l++) begin
            if (push_ok[l] && !reset) begin
                mem_q[l][wr_ptr_q[l]] <= bus.data_in;
            end
        end
    end

    assign bus.data_out0   = dout_q[0];
    assign bus.data_out1   = dout_q[1];
    assign bus.valid_out0  = valid_q[0];
    assign bus.valid_out1  = valid_q[1];
    assign bus.full_0      = full_q[0];
    assign bus.full_1      = full_q[1];
    assign bus.empty_0     = empty_q[0];
    assign bus.empty_1     = empty_q[1];
    assign bus.overflow_0  = ovf_q[0];
    assign bus.overflow_1  = ovf_q[1];
    assign bus.underflow_0 = udf_q[0];
    assign bus.underflow_1 = udf_q[1];
endmodule

// File: tb/tb_demux_memoria_2bits.sv
// Directed bench for the 1:2 memory demux; expected values are hand-derived.
module tb_demux_memoria_2bits;
    localparam int unsigned DATA_W = 2;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    demux_memoria_2bits_if #(.DATA_W(DATA_W)) bus ();

    demux_memoria_2bits #(.DATA_W(DATA_W), .DEPTH(4), .PTR_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.valid_in = 1'b0;
        bus.selector = 1'b0;
        bus.data_in  = '0;
        bus.pop_0    = 1'b0;
        bus.pop_1    = 1'b0;
    endtask

    task automatic push(input logic sel, input logic [1:0] d);
        idle();
        bus.valid_in = 1'b1;
        bus.selector = sel;
        bus.data_in  = d;
        tick();
        idle();
    endtask

    task automatic pop(input logic lane);
        idle();
        if (lane) bus.pop_1 = 1'b1;
        else      bus.pop_0 = 1'b1;
        tick();
        idle();
    endtask

    initial begin
        logic [1:0] w;
        n_vec = 0;
        n_err = 0;
        idle();

        // reset state
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_dout0", 8'(bus.data_out0), 8'd0);
        chk("rst_dout1", 8'(bus.data_out1), 8'd0);
        chk("rst_vout",  8'({bus.valid_out1, bus.valid_out0}), 8'd0);
        chk("rst_empty", 8'({bus.empty_1, bus.empty_0}), 8'd3);
        chk("rst_full",  8'({bus.full_1, bus.full_0}), 8'd0);
        chk("rst_err",   8'({bus.overflow_1, bus.overflow_0, bus.underflow_1, bus.underflow_0}), 8'd0);

        // alternating steer, then drain each lane
        push(1'b0, 2'd1);
        chk("alt_empty0_after_push", 8'(bus.empty_0), 8'd0);
        chk("alt_empty1_untouched", 8'(bus.empty_1), 8'd1);
        push(1'b1, 2'd2);
        push(1'b0, 2'd3);
        push(1'b1, 2'd0);
        bus.pop_0 = 1'b1; tick();
        chk("alt_l0_a", 8'({bus.valid_out0, bus.data_out0}), 8'h05);
        tick();
        chk("alt_l0_b", 8'({bus.valid_out0, bus.data_out0}), 8'h07);
        idle(); tick();
        chk("alt_l0_hold", 8'({bus.valid_out0, bus.data_out0}), 8'h03);
        chk("alt_empty0", 8'(bus.empty_0), 8'd1);
        bus.pop_1 = 1'b1; tick();
        chk("alt_l1_a", 8'({bus.valid_out1, bus.data_out1}), 8'h06);
        tick();
        chk("alt_l1_b", 8'({bus.valid_out1, bus.data_out1}), 8'h04);
        idle(); tick();
        chk("alt_l1_hold", 8'({bus.valid_out1, bus.data_out1}), 8'h00);
        chk("alt_empty1", 8'(bus.empty_1), 8'd1);

        // overflow on lane 0
        push(1'b0, 2'd3);
        push(1'b0, 2'd2);
        push(1'b0, 2'd1);
        chk("ovf_not_full_at3", 8'(bus.full_0), 8'd0);
        push(1'b0, 2'd0);
        chk("ovf_full_at4", 8'({bus.full_0, bus.overflow_0}), 8'h02);
        push(1'b0, 2'd3);
        chk("ovf_dropped", 8'({bus.full_0, bus.overflow_0}), 8'h03);
        chk("ovf_l1_flags", 8'({bus.empty_1, bus.full_1, bus.overflow_1, bus.underflow_1}), 8'h08);
        pop(1'b0); chk("ovf_drain0", 8'({bus.valid_out0, bus.data_out0}), 8'h07);
        pop(1'b0); chk("ovf_drain1", 8'({bus.valid_out0, bus.data_out0}), 8'h06);
        pop(1'b0); chk("ovf_drain2", 8'({bus.valid_out0, bus.data_out0}), 8'h05);
        pop(1'b0); chk("ovf_drain3", 8'({bus.valid_out0, bus.data_out0}), 8'h04);
        chk("ovf_empty_after", 8'({bus.empty_0, bus.underflow_0}), 8'h02);

        // lane 1 wrap: three fill/drain rounds
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) begin
                w = 2'(r + i);
                push(1'b1, w);
            end
            chk("wrap_full1", 8'(bus.full_1), 8'd1);
            for (int i = 0; i < 4; i++) begin
                w = 2'(r + i);
                pop(1'b1);
                chk("wrap_data1", 8'({bus.valid_out1, bus.data_out1}), 8'({1'b1, w}));
            end
        end
        chk("wrap_flags1", 8'({bus.empty_1, bus.overflow_1, bus.underflow_1}), 8'h04);

        // reset clears sticky flags, then same-cycle push+pop cases on lane 0
        reset = 1'b1; tick(); reset = 1'b0;
        chk("rst2_ovf0", 8'(bus.overflow_0), 8'd0);
        push(1'b0, 2'd1);
        push(1'b0, 2'd2);
        bus.valid_in = 1'b1; bus.selector = 1'b0; bus.data_in = 2'd2; bus.pop_0 = 1'b1;
        tick(); idle();
        chk("pp_old_head", 8'({bus.valid_out0, bus.data_out0}), 8'h05);
        chk("pp_count2", 8'({bus.empty_0, bus.full_0}), 8'h00);
        push(1'b0, 2'd3);
        push(1'b0, 2'd0);
        chk("pp_full", 8'({bus.full_0, bus.overflow_0}), 8'h02);
        bus.valid_in = 1'b1; bus.selector = 1'b0; bus.data_in = 2'd1; bus.pop_0 = 1'b1;
        tick(); idle();
        chk("ppf_head", 8'({bus.valid_out0, bus.data_out0}), 8'h06);
        chk("ppf_flags", 8'({bus.full_0, bus.overflow_0}), 8'h01);
        pop(1'b0); chk("ppf_d1", 8'({bus.valid_out0, bus.data_out0}), 8'h06);
        pop(1'b0); chk("ppf_d2", 8'({bus.valid_out0, bus.data_out0}), 8'h07);
        pop(1'b0); chk("ppf_d3", 8'({bus.valid_out0, bus.data_out0}), 8'h04);
        chk("ppf_empty", 8'(bus.empty_0), 8'd1);

        // underflow on empty lane 1 holds the last output
        push(1'b1, 2'd3);
        pop(1'b1);
        chk("udf_pre", 8'({bus.valid_out1, bus.data_out1, bus.underflow_1}), 8'h0E);
        pop(1'b1);
        chk("udf_hold", 8'({bus.valid_out1, bus.data_out1, bus.underflow_1}), 8'h07);

        // reset mid-operation with push and pop asserted
        push(1'b0, 2'd1);
        push(1'b0, 2'd2);
        push(1'b0, 2'd3);
        reset = 1'b1;
        bus.valid_in = 1'b1; bus.selector = 1'b0; bus.data_in = 2'd2; bus.pop_0 = 1'b1;
        tick();
        reset = 1'b0; idle();
        chk("mid_out", 8'({bus.valid_out0, bus.data_out0, bus.valid_out1, bus.data_out1}), 8'h00);
        chk("mid_flags", 8'({bus.empty_1, bus.empty_0, bus.full_1, bus.full_0}), 8'h0C);
        chk("mid_err", 8'({bus.overflow_1, bus.overflow_0, bus.underflow_1, bus.underflow_0}), 8'h00);
        pop(1'b0);
        chk("mid_udf0", 8'({bus.valid_out0, bus.data_out0, bus.underflow_0}), 8'h01);

        // push and pop on an empty lane: push lands, pop underflows
        bus.valid_in = 1'b1; bus.selector = 1'b1; bus.data_in = 2'd2; bus.pop_1 = 1'b1;
        tick(); idle();
        chk("pe_result", 8'({bus.valid_out1, bus.empty_1, bus.underflow_1}), 8'h01);
        pop(1'b1);
        chk("pe_data", 8'({bus.valid_out1, bus.data_out1, bus.empty_1}), 8'h0D);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
